uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
UART receive front end that converts the serial line into a parallel frame for the downstream even-parity checker. It samples the line with a 16x oversampling tick from the baud generator. It detects and validates the start bit, then shifts in DATA_BITS data bits (LSB first), one parity bit and one stop bit. It presents the frame on data_out with a single-cycle rx_done strobe, in exactly the layout the parity checker consumes.

Parameters:
DATA_BITS, 8, number of data bits per frame
NBITS, DATA_BITS+1, width of data_out (data bits plus one parity bit)
OVERSAMPLE, 16, s_tick pulses per bit period; mid-bit sample point is OVERSAMPLE/2-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_in  input  1  asynchronous serial line, idle high
s_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate
data_out  output  NBITS  data_out[NBITS-1:1] = received byte (data_out[1] = first bit on wire); data_out[0] = received parity bit
rx_done  output  1  one-clk pulse, frame complete, data_out valid
framing_error  output  1  one-clk pulse coincident with rx_done when stop bit sampled 0
rx_busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset: the FSM goes to IDLE. data_out=0, rx_done=0, framing_error=0, rx_busy=0. Tick and bit counters are 0. Both synchronizer flops are 1. The rearm flag is set.
- rx_in passes through a 2-flop synchronizer. All decisions use the synchronized line (rxs), which adds 2 clk of latency.
- Counters advance only on clk edges where s_tick=1. Exception: the IDLE start detect is evaluated every clk.
- IDLE: if rxs=0 and rearm=1, go to START, clear the tick counter and set rx_busy. If rxs=1, set rearm=1.
- START: on each tick, increment. At count OVERSAMPLE/2-1:
  - if rxs=0, clear the counter and go to DATA;
  - otherwise it is a glitch: go to IDLE with no rx_done.
- DATA: at count OVERSAMPLE-1, sample rxs into the next data position, clear the counter and increment the bit counter. After DATA_BITS samples, go to PARITY.
- PARITY: at count OVERSAMPLE-1, sample rxs as the parity bit and go to STOP.
- STOP: at count OVERSAMPLE-1, sample rxs, then on the same edge:
  - load data_out;
  - pulse rx_done;
  - set framing_error = ~rxs;
  - clear rx_busy;
  - go to IDLE.
- Sampling points are therefore mid-bit for every bit.
- No parity evaluation is done here; that belongs downstream.
- data_out updates only at frame completion. It holds its value between frames and during a glitched or aborted frame.
- On a framing error, clear rearm. The FSM does not start a new frame until rxs has been seen high for at least one clk. This prevents a break condition (line held low) from producing back-to-back garbage frames.
- rx_done and framing_error are registered pulses of exactly one clk, never asserted in any other cycle.
- Reset mid-frame: return to IDLE immediately. No rx_done, and data_out is cleared to 0.
- A frame may begin on the clk immediately after rx_done, with no idle gap required beyond the stop bit.
- s_tick held high continuously is legal: the block then oversamples at the clk rate.

Test Plan:
- Send 0xA5 with parity 0 and stop 1 (s_tick every 4 clk) -> exactly one rx_done; data_out=9'h14A; framing_error=0; rx_busy low afterwards.
- Send 0x07 with parity 1 and stop 1 -> data_out=9'h00F, rx_done pulse. Then send 0x00 with parity 0 immediately (back-to-back, no idle) -> second rx_done, data_out=9'h000.
- Drive rx_in low for 4 ticks then high (glitch) -> no rx_done; rx_busy returns to 0 after tick 8; data_out unchanged from its previous value.
- Send 0x3C with stop bit 0 -> rx_done and framing_error both pulse one clk; data_out=9'h078. Then hold the line low for 3 bit times -> no further rx_done until the line goes high and a new valid frame is sent.
- Assert rst for 1 clk during data bit 4 of a frame -> no rx_done; data_out=0. A following 0x55 frame (parity 0) is received correctly as 9'h0AA.
- Drive s_tick constantly high with OVERSAMPLE=16 and send 0xFF with parity 0 at 16 clk/bit -> data_out=9'h1FE, rx_done pulse.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// Signal bundle between the serial-line front end and the deserializer core.
// The slave side is the deserializer; the master side drives the line and the tick.
`timescale 1ns/1ps
interface uart_rx_deserializer_if #(
    parameter int NBITS = 9
);
    logic             rx_in;
    logic             s_tick;
    logic [NBITS-1:0] data_out;
    logic             rx_done;
    logic             framing_error;
    logic             rx_busy;

    modport master (
        output rx_in, s_tick,
        input  data_out, rx_done, framing_error, rx_busy
    );

    modport slave (
        input  rx_in, s_tick,
        output data_out, rx_done, framing_error, rx_busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x-oversampled start/data/parity/stop capture.
// Presents {data, parity} to the downstream parity checker with a one-clk rx_done.
`timescale 1ns/1ps
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int NBITS      = DATA_BITS + 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rxs;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic                 rearm;
    logic [NBITS-1:0]     data_q;
    logic                 done_q;
    logic                 ferr_q;
    logic                 busy_q;

    assign rxs               = sync[1];
    assign bus.data_out      = data_q;
    assign bus.rx_done       = done_q;
    assign bus.framing_error = ferr_q;
    assign bus.rx_busy       = busy_q;

    // NOTE: all state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sync     <= 2'b11;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            rearm    <= 1'b1;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync   <= {sync[0], bus.rx_in};
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Start detect runs every clk; rearm blocks restarts during a break.
                    if (rxs) begin
                        rearm <= 1'b1;
                    end else if (rearm) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                START: if (bus.s_tick) begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA: if (bus.s_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        shift    <= {rxs, shift[DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) state <= PARITY;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                PARITY: if (bus.s_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        parity   <= rxs;
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                STOP: if (bus.s_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        data_q   <= {shift, parity};
                        done_q   <= 1'b1;
                        ferr_q   <= ~rxs;
                        rearm    <= rxs;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames, glitch, break, reset abort, full-rate ticks.
// Expected frames are hand-computed as {byte, parity}.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   tick_div = 4;
    int   tick_phase = 0;
    int   done_cnt = 0;
    int   ferr_cnt = 0;
    logic [8:0] last_data = '0;
    logic       last_ferr = 1'b0;

    uart_rx_deserializer_if #(.NBITS(9)) bus ();

    uart_rx_deserializer #(
        .DATA_BITS (8),
        .NBITS     (9),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_phase >= tick_div - 1) begin
            tick_phase = 0;
            bus.s_tick = 1'b1;
        end else begin
            tick_phase++;
            bus.s_tick = 1'b0;
        end
    end

    // Pulse widths are counted in clk cycles, so a stuck strobe shows up as an extra count.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_done) begin
                done_cnt++;
                last_data = bus.data_out;
                last_ferr = bus.framing_error;
            end
            if (bus.framing_error) ferr_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rx_in = b;
        repeat (16 * tick_div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    initial begin
        int d0;
        int f0;
        logic [7:0] abort_byte;
        bus.rx_in  = 1'b1;
        bus.s_tick = 1'b0;

        repeat (4) @(negedge clk);
        check("rst_data", 32'(bus.data_out), 32'h0);
        check("rst_done", 32'(bus.rx_done), 32'h0);
        check("rst_ferr", 32'(bus.framing_error), 32'h0);
        check("rst_busy", 32'(bus.rx_busy), 32'h0);
        rst = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);

        d0 = done_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        send_bit(1'b1);
        check("a5_done", 32'(done_cnt - d0), 32'd1);
        check("a5_data", 32'(last_data), 32'h14A);
        check("a5_ferr", 32'(last_ferr), 32'h0);
        check("a5_busy", 32'(bus.rx_busy), 32'h0);

        d0 = done_cnt;
        bus.rx_in = 1'b0;
        repeat (16) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", 32'(bus.rx_busy), 32'h1);
        repeat (25) @(negedge clk);
        check("glitch_busy_lo", 32'(bus.rx_busy), 32'h0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("glitch_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_data", 32'(bus.data_out), 32'h14A);

        d0 = done_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        check("b2b_first_done", 32'(done_cnt - d0), 32'd1);
        check("b2b_first_data", 32'(last_data), 32'h00F);
        send_frame(8'h00, 1'b0, 1'b1);
        send_bit(1'b1);
        check("b2b_second_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_second_data", 32'(last_data), 32'h000);

        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("brk_done", 32'(done_cnt - d0), 32'd1);
        check("brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        check("brk_ferr", 32'(last_ferr), 32'h1);
        check("brk_data", 32'(last_data), 32'h078);
        check("brk_busy", 32'(bus.rx_busy), 32'h0);
        send_bit(1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        send_bit(1'b1);
        check("brk_recover_done", 32'(done_cnt - d0), 32'd2);
        check("brk_recover_data", 32'(last_data), 32'h102);
        check("brk_recover_ferr", 32'(ferr_cnt - f0), 32'd1);

        d0 = done_cnt;
        abort_byte = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(abort_byte[i]);
        bus.rx_in = abort_byte[4];
        repeat (32) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data", 32'(bus.data_out), 32'h0);
        check("abort_busy", 32'(bus.rx_busy), 32'h0);
        bus.rx_in = 1'b1;
        repeat (8) send_bit(1'b1);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_data_hold", 32'(bus.data_out), 32'h0);
        send_frame(8'h55, 1'b0, 1'b1);
        send_bit(1'b1);
        check("after_abort_done", 32'(done_cnt - d0), 32'd1);
        check("after_abort_data", 32'(last_data), 32'h0AA);
        check("after_abort_ferr", 32'(last_ferr), 32'h0);

        tick_div = 1;
        send_bit(1'b1);
        send_bit(1'b1);
        d0 = done_cnt;
        send_frame(8'hFF, 1'b0, 1'b1);
        send_bit(1'b1);
        check("fast_done", 32'(done_cnt - d0), 32'd1);
        check("fast_data", 32'(last_data), 32'h1FE);
        check("fast_busy", 32'(bus.rx_busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
